pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a multi-issue in-order pipeline.
// Detects load-use hazards between ID and EX slots, applies branch flushes and
// holds the pipe while a MEM-stage data access is outstanding. Control outputs
// are Mealy (same-cycle); the FSM state and bubble counter are registered.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall/flush
// performance counters; otherwise both counter outputs are tied to zero.

`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

module pipeline_hazard_ctrl #(
  parameter int unsigned ISSUE_WIDTH = `ISSUE_WIDTH,
  // Bubble cycles inserted per load-use hazard, 1..7.
  parameter int unsigned LU_BUBBLES  = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [ISSUE_WIDTH-1:0]      id_valid,
  input  logic [ISSUE_WIDTH-1:0]      id_uses_rs1,
  input  logic [ISSUE_WIDTH-1:0]      id_uses_rs2,
  input  logic [ISSUE_WIDTH-1:0][4:0] id_rs1,
  input  logic [ISSUE_WIDTH-1:0][4:0] id_rs2,
  input  logic [ISSUE_WIDTH-1:0]      ex_valid,
  input  logic [ISSUE_WIDTH-1:0]      ex_rd_mem,
  input  logic [ISSUE_WIDTH-1:0][4:0] ex_dest,
  input  logic                        ex_take_branch,
  input  logic                        mem_req,
  input  logic                        mem_ack,
  output logic                        stall_pc,
  output logic                        stall_ifid,
  output logic                        stall_exmem,
  output logic                        bubble_idex,
  output logic                        flush_ifid,
  output logic                        flush_idex,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 flush_count
);

  typedef enum logic [1:0] {
    Run     = 2'd0,
    LuStall = 2'd1,
    MemWait = 2'd2
  } state_e;

  // Control vector order: {stall_pc, stall_ifid, stall_exmem, bubble_idex, flush_ifid, flush_idex}
  localparam logic [5:0] CtlNone     = 6'b000000;
  localparam logic [5:0] CtlMemStall = 6'b111000;
  localparam logic [5:0] CtlLuStall  = 6'b110100;
  localparam logic [5:0] CtlFlush    = 6'b000011;

  // Counter value loaded on hazard entry; the entry cycle itself is the first bubble.
  localparam logic [2:0] LuReload = 3'(LU_BUBBLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;
  logic       mem_wait;
  logic [5:0] run_ctl;
  state_e     run_state;
  logic [2:0] run_cnt;
  logic [5:0] ctl;

  assign mem_wait = mem_req & ~mem_ack;

  // Load-use hit: any valid ID slot reading the non-zero destination of a load in any EX slot.
  always_comb begin
    lu_hit = 1'b0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
        if (id_valid[i] && ex_valid[j] && ex_rd_mem[j] && (ex_dest[j] != 5'd0)) begin
          if ((id_uses_rs1[i] && (id_rs1[i] == ex_dest[j])) ||
              (id_uses_rs2[i] && (id_rs2[i] == ex_dest[j]))) begin
            lu_hit = 1'b1;
          end
        end
      end
    end
  end

  // RUN-state decision, shared by RUN and by the MEM_WAIT exit cycle.
  always_comb begin
    run_ctl   = CtlNone;
    run_state = Run;
    run_cnt   = 3'd0;
    if (mem_wait) begin
      run_ctl   = CtlMemStall;
      run_state = MemWait;
    end else if (ex_take_branch) begin
      run_ctl = CtlFlush;
    end else if (lu_hit) begin
      run_ctl = CtlLuStall;
      if (LU_BUBBLES > 1) begin
        run_state = LuStall;
        run_cnt   = LuReload;
      end
    end
  end

  // Next-state and Mealy control outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = CtlNone;
    unique case (state_q)
      Run: begin
        ctl     = run_ctl;
        state_d = run_state;
        cnt_d   = run_cnt;
      end
      LuStall: begin
        if (mem_wait) begin
          // Older access still busy in MEM: freeze the bubble count until it completes.
          ctl = CtlLuStall | CtlMemStall;
        end else if (ex_take_branch) begin
          // EX should hold a bubble here; honour a branch anyway and drop the stall.
          ctl     = CtlFlush;
          state_d = Run;
          cnt_d   = 3'd0;
        end else begin
          ctl = CtlLuStall;
          if (cnt_q <= 3'd1) begin
            state_d = Run;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      MemWait: begin
        if (mem_ack) begin
          // Stage contents were held, so re-evaluating them now loses no event.
          ctl     = run_ctl;
          state_d = run_state;
          cnt_d   = run_cnt;
        end else begin
          ctl = CtlMemStall;
        end
      end
      default: begin
        state_d = Run;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and bubble counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Run;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign {stall_pc, stall_ifid, stall_exmem, bubble_idex, flush_ifid, flush_idex} =
      ctl & {6{reset_n}};

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_ifid && (flush_count_q != 32'hFFFF_FFFF)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LU_BUBBLES = 1 and 3) share one
// stimulus stream. Directed scenarios first, then randomized cycles checked against
// a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned W = 2;

`ifdef HAZARD_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // {stall_pc, stall_ifid, stall_exmem, bubble_idex, flush_ifid, flush_idex}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] MEMS = 6'b111000;
  localparam logic [5:0] LUS  = 6'b110100;
  localparam logic [5:0] FLSH = 6'b000011;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [W-1:0]      id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_mem;
  logic [W-1:0][4:0] id_rs1, id_rs2, ex_dest;
  logic              ex_take_branch, mem_req, mem_ack;

  logic        spc1, sif1, sem1, bub1, fif1, fid1;
  logic        spc3, sif3, sem3, bub3, fif3, fid3;
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [5:0]  ctl1, ctl3;

  assign ctl1 = {spc1, sif1, sem1, bub1, fif1, fid1};
  assign ctl3 = {spc3, sif3, sem3, bub3, fif3, fid3};

  pipeline_hazard_ctrl #(.ISSUE_WIDTH(W), .LU_BUBBLES(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_rd_mem(ex_rd_mem), .ex_dest(ex_dest),
    .ex_take_branch(ex_take_branch), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_pc(spc1), .stall_ifid(sif1), .stall_exmem(sem1),
    .bubble_idex(bub1), .flush_ifid(fif1), .flush_idex(fid1),
    .stall_cycles(sc1), .flush_count(fc1)
  );

  pipeline_hazard_ctrl #(.ISSUE_WIDTH(W), .LU_BUBBLES(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_rd_mem(ex_rd_mem), .ex_dest(ex_dest),
    .ex_take_branch(ex_take_branch), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_pc(spc3), .stall_ifid(sif3), .stall_exmem(sem3),
    .bubble_idex(bub3), .flush_ifid(fif3), .flush_idex(fid3),
    .stall_cycles(sc3), .flush_count(fc3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: remaining extra bubbles, waiting on dmem, perf counts.
  int          lub     [2] = '{1, 3};
  int          lu_left [2] = '{0, 0};
  bit          in_wait [2] = '{0, 0};
  int unsigned exp_sc  [2] = '{0, 0};
  int unsigned exp_fc  [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    bit hit = 1'b0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (id_valid[i] && ex_valid[j] && ex_rd_mem[j] && ex_dest[j] != 5'd0 &&
            ((id_uses_rs1[i] && id_rs1[i] == ex_dest[j]) ||
             (id_uses_rs2[i] && id_rs2[i] == ex_dest[j]))) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // One cycle of the reference behaviour for instance k.
  function automatic logic [5:0] model_out(input int k, output bit w_n, output int l_n);
    logic [5:0] c = NONE;
    w_n = 1'b0;
    l_n = 0;
    if (lu_left[k] > 0) begin
      if (ex_take_branch) c = FLSH;
      else begin
        c   = LUS;
        l_n = lu_left[k] - 1;
      end
    end else if ((mem_req || in_wait[k]) && !mem_ack) begin
      c   = MEMS;
      w_n = 1'b1;
    end else if (ex_take_branch) begin
      c = FLSH;
    end else if (hazard()) begin
      c   = LUS;
      l_n = lub[k] - 1;
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lu_left[k] = 0;
      in_wait[k] = 1'b0;
      exp_sc[k]  = 0;
      exp_fc[k]  = 0;
    end
  endtask

  task automatic clear_inputs();
    id_valid = '0; id_uses_rs1 = '0; id_uses_rs2 = '0; id_rs1 = '0; id_rs2 = '0;
    ex_valid = '0; ex_rd_mem = '0; ex_dest = '0;
    ex_take_branch = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // EX slot1 lw x5; ID slot0 add x?, x3, x5.
  task automatic set_lw_x5_hazard();
    clear_inputs();
    ex_valid[1] = 1'b1; ex_rd_mem[1] = 1'b1; ex_dest[1] = 5'd5;
    id_valid[0] = 1'b1; id_uses_rs1[0] = 1'b1; id_rs1[0] = 5'd3;
    id_uses_rs2[0] = 1'b1; id_rs2[0] = 5'd5;
  endtask

  // Inputs are set by the caller; outputs checked at negedge, model advanced at posedge.
  task automatic step(input string tag, input bit directed, input logic [5:0] e1,
                      input logic [5:0] e3);
    logic [5:0] m  [2];
    bit         wn [2];
    int         ln [2];
    @(negedge clock);
    for (int k = 0; k < 2; k++) m[k] = model_out(k, wn[k], ln[k]);
    if (directed) begin
      m[0] = e1;
      m[1] = e3;
    end
    check({tag, "/lu1_ctl"}, 32'(ctl1), 32'(m[0]));
    check({tag, "/lu3_ctl"}, 32'(ctl3), 32'(m[1]));
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      in_wait[k] = wn[k];
      lu_left[k] = ln[k];
      if (m[k][5]) exp_sc[k]++;
      if (m[k][1]) exp_fc[k]++;
    end
    #1;
    check({tag, "/lu1_stalls"}, sc1, PerfEn ? exp_sc[0] : 32'd0);
    check({tag, "/lu1_flushes"}, fc1, PerfEn ? exp_fc[0] : 32'd0);
    check({tag, "/lu3_stalls"}, sc3, PerfEn ? exp_sc[1] : 32'd0);
    check({tag, "/lu3_flushes"}, fc3, PerfEn ? exp_fc[1] : 32'd0);
  endtask

  initial begin
    // Reset held with a hazard on the inputs: everything must read zero.
    set_lw_x5_hazard();
    ex_take_branch = 1'b1;
    #12;
    check("rst_ctl1", 32'(ctl1), 32'(NONE));
    check("rst_ctl3", 32'(ctl3), 32'(NONE));
    check("rst_sc1", sc1, 32'd0);
    check("rst_fc3", fc3, 32'd0);
    clear_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Load-use: LU_BUBBLES=1 stalls once, LU_BUBBLES=3 stalls three cycles.
    set_lw_x5_hazard();
    step("lu_a", 1'b1, LUS, LUS);
    clear_inputs();
    step("lu_b", 1'b1, NONE, LUS);
    step("lu_c", 1'b1, NONE, LUS);
    step("lu_d", 1'b1, NONE, NONE);

    // Branch wins over load-use.
    set_lw_x5_hazard();
    ex_take_branch = 1'b1;
    step("br_lu", 1'b1, FLSH, FLSH);
    clear_inputs();
    step("br_after", 1'b1, NONE, NONE);

    // dmem wait for 4 cycles with a pending branch: flush once on the ack cycle.
    ex_take_branch = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step("mw_hold", 1'b1, MEMS, MEMS);
    mem_ack = 1'b1;
    step("mw_ack", 1'b1, FLSH, FLSH);
    clear_inputs();
    step("mw_after", 1'b1, NONE, NONE);

    // Accumulated perf totals for the directed sequence so far.
    check("perf_lu1_stalls", sc1, PerfEn ? 32'd5 : 32'd0);
    check("perf_lu3_stalls", sc3, PerfEn ? 32'd7 : 32'd0);
    check("perf_lu1_flushes", fc1, PerfEn ? 32'd2 : 32'd0);
    check("perf_lu3_flushes", fc3, PerfEn ? 32'd2 : 32'd0);

    // mem_req with mem_ack in the same cycle does not stall.
    mem_req = 1'b1; mem_ack = 1'b1;
    step("req_ack", 1'b1, NONE, NONE);

    // x0 never hazards.
    clear_inputs();
    ex_valid = 2'b11; ex_rd_mem = 2'b11; ex_dest[0] = 5'd0; ex_dest[1] = 5'd0;
    id_valid = 2'b11; id_uses_rs1 = 2'b11; id_uses_rs2 = 2'b11;
    step("x0", 1'b1, NONE, NONE);

    // Reset in the middle of a 3-bubble sequence.
    set_lw_x5_hazard();
    step("rlu_a", 1'b1, LUS, LUS);
    clear_inputs();
    @(negedge clock);
    check("rlu_mid", 32'(ctl3), 32'(LUS));
    #1 reset_n = 1'b0;
    #1;
    check("rlu_async3", 32'(ctl3), 32'(NONE));
    check("rlu_async_sc3", sc3, 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step("rlu_post", 1'b1, NONE, NONE);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < W; i++) begin
        id_valid[i]    = ($urandom_range(0, 3) != 0);
        id_uses_rs1[i] = $urandom_range(0, 1);
        id_uses_rs2[i] = $urandom_range(0, 1);
        id_rs1[i]      = 5'($urandom_range(0, 3));
        id_rs2[i]      = 5'($urandom_range(0, 3));
        ex_valid[i]    = $urandom_range(0, 1);
        ex_rd_mem[i]   = $urandom_range(0, 1);
        ex_dest[i]     = 5'($urandom_range(0, 3));
      end
      ex_take_branch = ($urandom_range(0, 7) == 0);
      mem_req = (lu_left[0] == 0 && lu_left[1] == 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
      mem_ack = $urandom_range(0, 1);
      step("rand", 1'b0, NONE, NONE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
